// File: rtl/pipeline_pkg.sv
// Shared types for the 5-stage pipeline control path: hazard FSM states,
// the ID/EX control bundle with its bubble value, and a saturating counter helper.
package pipeline_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2
   } hazard_state_t;

   typedef struct packed {
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] alu_op;
   } ctrl_bubble_t;

   localparam ctrl_bubble_t CTRL_BUBBLE = '{
      alu_src:    1'b0,
      mem_to_reg: 1'b0,
      reg_write:  1'b0,
      mem_read:   1'b0,
      mem_write:  1'b0,
      alu_op:     2'b00
   };

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/hazard_load_use_det.sv
// Load-use detector: the load in ID/EX writes a register the ID instruction reads.
// Kept standalone so the forwarding unit can reuse the same register match.
module hazard_load_use_det #(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] if_id_rs1,
   input  logic [REG_W-1:0] if_id_rs2,
   input  logic             if_id_uses_rs2,
   input  logic             id_ex_MemRead,
   input  logic [REG_W-1:0] id_ex_rd,
   output logic             load_use
);

   logic rd_nonzero_s;
   logic rs1_match_s;
   logic rs2_match_s;

   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   assign rd_nonzero_s = (id_ex_rd != {REG_W{1'b0}});
   assign rs1_match_s  = (id_ex_rd == if_id_rs1);
   assign rs2_match_s  = if_id_uses_rs2 & (id_ex_rd == if_id_rs2);
   assign load_use     = id_ex_MemRead & rd_nonzero_s & (rs1_match_s | rs2_match_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller: drives pipeline register enables, flushes and
// bubbles for dmem waits, taken-branch redirects and load-use dependencies.
module pipeline_hazard_ctrl #(
   parameter int FLUSH_EXTRA = 1,
   parameter int MEM_TIMEOUT = 255,
   parameter int REG_W       = 5,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] if_id_rs1,
   input  logic [REG_W-1:0] if_id_rs2,
   input  logic             if_id_uses_rs2,
   input  logic             id_ex_MemRead,
   input  logic [REG_W-1:0] id_ex_rd,
   input  logic             branch_taken,
   input  logic             ex_mem_access,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_bubble,
   output logic             ex_mem_write,
   output logic             mem_wb_bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles
);
   import pipeline_pkg::*;

   hazard_state_t    state_r, next_state_s;
   hazard_state_t    ret_state_r, ret_state_nxt_s;
   hazard_state_t    eff_state_s;
   logic [2:0]       flush_cnt_r, flush_cnt_nxt_s;
   logic [15:0]      wait_cnt_r, wait_cnt_nxt_s;
   logic             mem_err_r, mem_err_nxt_s;
   logic [CNT_W-1:0] stall_cnt_r;
   logic             load_use_s;
   logic             mem_stall_s;
   logic             pc_write_s, if_id_write_s, id_ex_write_s, ex_mem_write_s;
   logic             if_id_flush_s, id_ex_bubble_s, mem_wb_bubble_s;

   hazard_load_use_det #(.REG_W(REG_W)) u_load_use_det (
      .if_id_rs1      (if_id_rs1),
      .if_id_rs2      (if_id_rs2),
      .if_id_uses_rs2 (if_id_uses_rs2),
      .id_ex_MemRead  (id_ex_MemRead),
      .id_ex_rd       (id_ex_rd),
      .load_use       (load_use_s)
   );

   assign mem_stall_s = ex_mem_access & ~dmem_ready;
   // The release cycle of a dmem wait behaves like the state that was interrupted
   assign eff_state_s = (state_r == MEM_WAIT) ? ret_state_r : state_r;

   // Next-state and hazard control decode, priority mem stall > branch > load-use
   always_comb begin
      pc_write_s      = 1'b1;
      if_id_write_s   = 1'b1;
      id_ex_write_s   = 1'b1;
      ex_mem_write_s  = 1'b1;
      if_id_flush_s   = 1'b0;
      id_ex_bubble_s  = 1'b0;
      mem_wb_bubble_s = 1'b0;
      next_state_s    = state_r;
      ret_state_nxt_s = ret_state_r;
      flush_cnt_nxt_s = flush_cnt_r;
      wait_cnt_nxt_s  = 16'd0;
      mem_err_nxt_s   = mem_err_r;
      if (mem_stall_s) begin
         pc_write_s      = 1'b0;
         if_id_write_s   = 1'b0;
         id_ex_write_s   = 1'b0;
         ex_mem_write_s  = 1'b0;
         mem_wb_bubble_s = 1'b1;
         next_state_s    = MEM_WAIT;
         wait_cnt_nxt_s  = sat_inc16(wait_cnt_r);
         if (state_r != MEM_WAIT) begin
            ret_state_nxt_s = state_r;
         end else begin
            ret_state_nxt_s = ret_state_r;
         end
         if (wait_cnt_nxt_s >= 16'(MEM_TIMEOUT)) begin
            mem_err_nxt_s = 1'b1;
         end else begin
            mem_err_nxt_s = mem_err_r;
         end
      end else begin
         case (eff_state_s)
            RUN: begin
               next_state_s = RUN;
               if (branch_taken) begin
                  if_id_flush_s  = 1'b1;
                  id_ex_bubble_s = 1'b1;
                  if (FLUSH_EXTRA > 0) begin
                     next_state_s    = FLUSH;
                     flush_cnt_nxt_s = 3'(FLUSH_EXTRA);
                  end else begin
                     next_state_s = RUN;
                  end
               end else if (load_use_s) begin
                  pc_write_s     = 1'b0;
                  if_id_write_s  = 1'b0;
                  id_ex_bubble_s = 1'b1;
               end else begin
                  next_state_s = RUN;
               end
            end
            FLUSH: begin
               if_id_flush_s  = 1'b1;
               id_ex_bubble_s = 1'b1;
               if (flush_cnt_r <= 3'd1) begin
                  next_state_s    = RUN;
                  flush_cnt_nxt_s = 3'd0;
               end else begin
                  next_state_s    = FLUSH;
                  flush_cnt_nxt_s = flush_cnt_r - 3'd1;
               end
            end
            default: begin
               next_state_s = RUN;
            end
         endcase
      end
   end

   // FSM, flush/wait counters, saved return state and sticky timeout flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= RUN;
         ret_state_r <= RUN;
         flush_cnt_r <= 3'd0;
         wait_cnt_r  <= 16'd0;
         mem_err_r   <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         ret_state_r <= ret_state_nxt_s;
         flush_cnt_r <= flush_cnt_nxt_s;
         wait_cnt_r  <= wait_cnt_nxt_s;
         mem_err_r   <= mem_err_nxt_s;
      end
   end

   // Saturating count of cycles in which the PC was held
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (!pc_write_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   // Reset holds every register and injects bubbles without waiting for a clock
   assign pc_write      = rst ? 1'b0 : pc_write_s;
   assign if_id_write   = rst ? 1'b0 : if_id_write_s;
   assign id_ex_write   = rst ? 1'b0 : id_ex_write_s;
   assign ex_mem_write  = rst ? 1'b0 : ex_mem_write_s;
   assign if_id_flush   = rst ? 1'b1 : if_id_flush_s;
   assign id_ex_bubble  = rst ? 1'b1 : id_ex_bubble_s;
   assign mem_wb_bubble = rst ? 1'b1 : mem_wb_bubble_s;
   assign mem_err       = mem_err_r;
   assign stall_cycles  = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (FLUSH_EXTRA=2, MEM_TIMEOUT=3):
// directed vectors push hand-computed expectations, a negedge monitor checks them.
module tb_pipeline_hazard_ctrl;

   localparam logic [6:0] RUN_C = 7'b1111_000;
   localparam logic [6:0] LU_C  = 7'b0011_010;
   localparam logic [6:0] FL_C  = 7'b1111_110;
   localparam logic [6:0] MS_C  = 7'b0000_001;
   localparam logic [6:0] RST_C = 7'b0000_111;

   typedef struct {
      logic [6:0]  ctrl;
      logic        err;
      logic        chk_err;
      logic [31:0] cnt;
      string       nm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  if_id_rs1 = 5'd1;
   logic [4:0]  if_id_rs2 = 5'd2;
   logic        if_id_uses_rs2 = 1'b0;
   logic        id_ex_MemRead = 1'b0;
   logic [4:0]  id_ex_rd = 5'd0;
   logic        branch_taken = 1'b0;
   logic        ex_mem_access = 1'b0;
   logic        dmem_ready = 1'b1;
   logic        pc_write, if_id_write, if_id_flush, id_ex_write;
   logic        id_ex_bubble, ex_mem_write, mem_wb_bubble, mem_err;
   logic [31:0] stall_cycles;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   pipeline_hazard_ctrl #(
      .FLUSH_EXTRA (2),
      .MEM_TIMEOUT (3),
      .REG_W       (5),
      .CNT_W       (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .if_id_rs1      (if_id_rs1),
      .if_id_rs2      (if_id_rs2),
      .if_id_uses_rs2 (if_id_uses_rs2),
      .id_ex_MemRead  (id_ex_MemRead),
      .id_ex_rd       (id_ex_rd),
      .branch_taken   (branch_taken),
      .ex_mem_access  (ex_mem_access),
      .dmem_ready     (dmem_ready),
      .pc_write       (pc_write),
      .if_id_write    (if_id_write),
      .if_id_flush    (if_id_flush),
      .id_ex_write    (id_ex_write),
      .id_ex_bubble   (id_ex_bubble),
      .ex_mem_write   (ex_mem_write),
      .mem_wb_bubble  (mem_wb_bubble),
      .mem_err        (mem_err),
      .stall_cycles   (stall_cycles)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the rising edge and queue its expectation
   task automatic step(input logic r, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                       input logic br, input logic acc, input logic rdy,
                       input logic [6:0] ec, input logic ee, input logic ce,
                       input int cnt, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst            = r;
      id_ex_MemRead  = mr;
      id_ex_rd       = rd;
      if_id_rs1      = rs1;
      if_id_rs2      = rs2;
      if_id_uses_rs2 = u2;
      branch_taken   = br;
      ex_mem_access  = acc;
      dmem_ready     = rdy;
      e.ctrl = ec;
      e.err = ee;
      e.chk_err = ce;
      e.cnt = 32'(cnt);
      e.nm = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: outputs are valid every cycle, so compare one expectation per falling edge
   initial begin
      exp_t e;
      logic [6:0] got;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                   if_id_flush, id_ex_bubble, mem_wb_bubble};
            tests++;
            if (got !== e.ctrl) begin
               fails++;
               $display("FAIL %s ctrl: got %b want %b", e.nm, got, e.ctrl);
            end
            tests++;
            if (stall_cycles !== e.cnt) begin
               fails++;
               $display("FAIL %s stall_cycles: got %0d want %0d", e.nm, stall_cycles, e.cnt);
            end
            if (e.chk_err) begin
               tests++;
               if (mem_err !== e.err) begin
                  fails++;
                  $display("FAIL %s mem_err: got %b want %b", e.nm, mem_err, e.err);
               end
            end
         end
      end
   end

   initial begin
      //    rst mr rd    rs1   rs2   u2 br acc rdy  ctrl  err chk cnt
      step(1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1, RST_C, 0, 1, 0, "reset");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1, RUN_C, 0, 1, 0, "idle");
      step(0, 1, 5'd5, 5'd5, 5'd2, 0, 0, 0, 1, LU_C,  0, 1, 0, "lu_rs1");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1, RUN_C, 0, 1, 1, "lu_clear");
      step(0, 1, 5'd0, 5'd0, 5'd2, 0, 0, 0, 1, RUN_C, 0, 1, 1, "x0_rd");
      step(0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 1, RUN_C, 0, 1, 1, "rs2_unused");
      step(0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 1, LU_C,  0, 1, 1, "rs2_used");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1, RUN_C, 0, 1, 2, "after_rs2");
      // branch and load-use together: branch wins, then two extra flush cycles
      step(0, 1, 5'd5, 5'd5, 5'd2, 0, 1, 0, 1, FL_C,  0, 1, 2, "br_vs_lu");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1, FL_C,  0, 1, 2, "flush2");
      step(0, 1, 5'd5, 5'd5, 5'd2, 0, 1, 0, 1, FL_C,  0, 1, 2, "flush3_ign");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1, RUN_C, 0, 1, 2, "br_done");
      // dmem wait inside a flush freezes it; flush resumes afterwards
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0, 1, FL_C,  0, 1, 2, "br2");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 0, MS_C,  0, 1, 2, "fw_stall1");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 0, MS_C,  0, 1, 3, "fw_stall2");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 0, MS_C,  0, 0, 4, "fw_stall3");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 0, MS_C,  0, 0, 5, "fw_stall4");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 1, FL_C,  1, 1, 6, "fw_resume");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1, FL_C,  1, 1, 6, "fw_last");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1, RUN_C, 1, 1, 6, "fw_done");
      // timeout: five stalled cycles against MEM_TIMEOUT=3
      step(1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1, RST_C, 0, 1, 0, "reset2");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 0, MS_C,  0, 1, 0, "to_1");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 0, MS_C,  0, 1, 1, "to_2");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 0, MS_C,  0, 0, 2, "to_3");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 0, MS_C,  1, 1, 3, "to_4");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 0, MS_C,  1, 1, 4, "to_5");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 1, RUN_C, 1, 1, 5, "to_ready");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1, RUN_C, 1, 1, 5, "to_sticky");
      // reset raised between edges while in FLUSH
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0, 1, FL_C,  1, 1, 5, "br3");
      step(1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1, RST_C, 0, 1, 0, "rst_async");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1, RUN_C, 0, 1, 0, "after_rst");
      step(0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 1, RUN_C, 0, 1, 0, "after_rst2");
      repeat (3) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and stall controller for the 5-stage 64-bit pipeline.
- Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC by generating write-enable, flush and bubble controls.
- Handles three hazard types:
  - Load-use hazards: detected from ID/EX control/register fields against the IF/ID source fields.
  - Taken-branch redirects: multi-cycle flush.
  - Data-memory wait: ready handshake with timeout.

Parameters:
- FLUSH_EXTRA, 1, extra flush cycles after the redirect cycle (0..7); covers fetch latency.
- MEM_TIMEOUT, 255, maximum consecutive dmem wait cycles before mem_err sets (1..65535).
- REG_W, 5, register index width.
- CNT_W, 32, width of the stall statistics counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- if_id_rs1  in  REG_W  rs1 index of the instruction in ID.
- if_id_rs2  in  REG_W  rs2 index of the instruction in ID.
- if_id_uses_rs2  in  1  instruction in ID reads rs2.
- id_ex_MemRead  in  1  MemRead_out of the ID/EX register.
- id_ex_rd  in  REG_W  rd_out of the ID/EX register.
- branch_taken  in  1  taken-branch/jump resolved in EX this cycle.
- ex_mem_access  in  1  instruction in MEM performs a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID register loads a NOP.
- id_ex_write  out  1  ID/EX register enable.
- id_ex_bubble  out  1  ID/EX loads zeroed controls (AluSrc/MemtoReg/RegWrite/MemRead/MemWrite/Aluop = 0).
- ex_mem_write  out  1  EX/MEM register enable.
- mem_wb_bubble  out  1  MEM/WB loads zeroed controls.
- mem_err  out  1  sticky: dmem wait exceeded MEM_TIMEOUT.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.

Behaviour:
- FSM states: RUN, FLUSH, MEM_WAIT. State, flush counter (3 bit), wait counter (16 bit), return-state register, mem_err and stall_cycles are registered.
- All control outputs are combinational from state and inputs: zero-cycle latency, as hazard controls must act in the detecting cycle.
- While rst=1 (asynchronous):
  - State RUN, counters 0, mem_err=0, stall_cycles=0.
  - Outputs forced: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_write=0, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1.
  - Reset mid-operation abandons any flush or wait immediately.
- Default (RUN, no hazard): all *_write=1; all flush/bubble outputs 0.
- Priority: mem stall > branch > load-use.
- Mem stall condition: ex_mem_access=1 and dmem_ready=0, in any state. Response:
  - pc_write, if_id_write, id_ex_write and ex_mem_write all 0; mem_wb_bubble=1; flush outputs 0.
  - Next state MEM_WAIT; the return state (RUN or FLUSH) and flush counter are saved and frozen.
- MEM_WAIT:
  - The wait counter increments each stalled cycle.
  - When the counter reaches MEM_TIMEOUT, mem_err sets and stays set until rst; the stall continues.
  - In the cycle dmem_ready=1, outputs follow the saved state's normal rules, the wait counter clears, and next state is the saved state.
- Branch redirect (branch_taken=1, not mem-stalled, state RUN):
  - pc_write=1, if_id_flush=1, id_ex_bubble=1.
  - If FLUSH_EXTRA>0: next state FLUSH with counter=FLUSH_EXTRA. Otherwise remain in RUN.
- FLUSH:
  - if_id_flush=1, id_ex_bubble=1, pc_write=1.
  - Counter decrements each non-stalled cycle; at 1, next state is RUN.
  - branch_taken is ignored (it comes from a squashed instruction), as is load-use.
- Load-use (state RUN, no branch, no mem stall): condition is id_ex_MemRead=1 and id_ex_rd≠0 and (id_ex_rd==if_id_rs1 or (if_id_uses_rs2 and id_ex_rd==if_id_rs2)). Response:
  - pc_write=0, if_id_write=0, id_ex_bubble=1; other enables stay 1.
  - One cycle only: the load advances and the hazard clears. No state change.
- Simultaneous branch_taken and load-use: the branch wins, since the dependent instruction is squashed.
- stall_cycles increments on every post-reset cycle with pc_write=0 and saturates at all-ones.

Decomposition:
- Package pipeline_pkg:
  - hazard_state_t enum {RUN, FLUSH, MEM_WAIT}.
  - REG_W localparam.
  - A ctrl_bubble_t struct of the ID/EX control fields with its all-zero constant.
- Sub-module hazard_load_use_det: purely combinational comparator producing load_use; isolates the register-match logic for reuse by the forwarding unit.

Test Plan:
- Load-use: id_ex_MemRead=1, id_ex_rd=5, if_id_rs1=5 for one cycle -> that cycle pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle (MemRead=0) all enables 1; stall_cycles=1.
- x0 and rs2 gating:
  - id_ex_rd=0, if_id_rs1=0, MemRead=1 -> no stall.
  - id_ex_rd=7, if_id_rs2=7, if_id_uses_rs2=0 -> no stall.
  - Same with if_id_uses_rs2=1 -> stall.
- Branch with FLUSH_EXTRA=2: branch_taken pulse -> if_id_flush=1 and id_ex_bubble=1 for exactly 3 cycles with pc_write=1 throughout; load-use raised during cycle 2 is ignored; RUN on cycle 4.
- Mem wait inside flush: branch, then ex_mem_access=1 with dmem_ready=0 for 4 cycles during FLUSH -> all enables 0 and mem_wb_bubble=1 for 4 cycles; afterwards the remaining flush cycles complete; total if_id_flush cycles still 3.
- Timeout with MEM_TIMEOUT=3: dmem_ready held 0 for 5 cycles -> mem_err rises at the 3rd stalled cycle and stays 1 after dmem_ready=1 until rst; stall_cycles=5.
- Async reset mid-FLUSH: assert rst between clock edges -> outputs take reset values immediately; after release the state is RUN with no residual flush and stall_cycles=0.
